// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared widths, constants and FSM state type for the
//                divider request controller and its FIFO.
//  Contents    : DIV_A_W / DIV_B_W / DIV_Q_W / DIV_R_W operand and result
//                widths, DBZ_QUOT divide-by-zero quotient, div_state_e.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_A_W = 16;
    localparam int DIV_B_W = 8;
    localparam int DIV_Q_W = 16;
    localparam int DIV_R_W = 16;

    // Quotient reported when the divisor is zero (core output is ignored).
    localparam logic [DIV_Q_W-1:0] DBZ_QUOT = 16'hFFFF;

    // IDLE  : request FIFO empty, nothing on the core
    // EVAL  : FIFO head is being evaluated by the core this cycle
    // STALL : head evaluated, waiting for the output register to free up
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        STALL = 2'd2
    } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : div_req_fifo
//  Description : In-order synchronous FIFO, DEPTH x WIDTH, wrap-around
//                pointers plus an occupancy counter. Pushes when full and
//                pops when empty are ignored.
//  Ports       : clk, rst (async, active-high)
//                push, push_data  - write side
//                pop              - advance the head
//                head_data        - current head entry (undefined if empty)
//                empty, count     - occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module div_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push & (r_count != c_depth);
    assign w_do_pop  = pop  & (r_count != '0);

    assign head_data = r_mem[r_rd_ptr];
    assign empty     = (r_count == '0);
    assign count     = r_count;

    // Storage carries no reset: contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : div_req_fifo
`default_nettype wire

// File: rtl/div_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_req_ctrl
//  Description : Request front-end / result back-end for a combinational
//                16-by-8 divider core. Buffers requests in a FIFO, presents
//                the head to the core for one cycle and captures quotient,
//                remainder, tag and divide-by-zero status into a registered,
//                back-pressurable output.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, in_a, in_b, in_tag  - request input
//                div_a, div_b -> core, div_quot, div_rem <- core
//                out_valid/out_ready, out_quot, out_rem, out_tag, out_dbz
//                count (FIFO occupancy), busy
//  Revision    : 1.0  initial release
// ============================================================================
module div_req_ctrl
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIV_A_W-1:0]           in_a,
    input  logic [DIV_B_W-1:0]           in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic [DIV_A_W-1:0]           div_a,
    output logic [DIV_B_W-1:0]           div_b,
    input  logic [DIV_Q_W-1:0]           div_quot,
    input  logic [DIV_R_W-1:0]           div_rem,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIV_Q_W-1:0]           out_quot,
    output logic [DIV_R_W-1:0]           out_rem,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_dbz,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);

    localparam int c_cnt_w   = $clog2(DEPTH+1);
    localparam int c_entry_w = DIV_A_W + DIV_B_W + TAG_W;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    div_state_e           r_state;
    logic                 w_push;
    logic                 w_capture;
    logic                 w_more;
    logic                 w_empty;
    logic                 w_dbz;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;
    logic [DIV_A_W-1:0]   w_head_a;
    logic [DIV_B_W-1:0]   w_head_b;
    logic [TAG_W-1:0]     w_head_tag;

    // Ready looks only at the registered occupancy; a pop in the same cycle
    // does not open a slot for a push.
    assign in_ready    = (count < c_depth);
    assign w_push      = in_valid & in_ready;
    assign w_push_data = {in_tag, in_b, in_a};

    div_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_capture),
        .head_data (w_head),
        .empty     (w_empty),
        .count     (count)
    );

    assign w_head_a   = w_head[DIV_A_W-1:0];
    assign w_head_b   = w_head[DIV_A_W +: DIV_B_W];
    assign w_head_tag = w_head[DIV_A_W+DIV_B_W +: TAG_W];

    // Quiet operands into the core when there is nothing to evaluate.
    assign div_a = w_empty ? '0 : w_head_a;
    assign div_b = w_empty ? '0 : w_head_b;

    assign w_dbz     = (w_head_b == '0);
    // EVAL/STALL always imply a non-empty FIFO, so capture never pops empty.
    assign w_capture = (r_state != IDLE) & (~out_valid | out_ready);
    // Another head will be on the core after this capture.
    assign w_more    = (count > c_one) | w_push;

    assign busy = (count != '0) | out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_tag   <= '0;
            out_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state <= EVAL;
                    end
                end
                EVAL, STALL: begin
                    if (w_capture) begin
                        r_state <= w_more ? EVAL : IDLE;
                    end else begin
                        r_state <= STALL;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_capture) begin
                out_valid <= 1'b1;
                out_tag   <= w_head_tag;
                out_dbz   <= w_dbz;
                // Core result is meaningless for a zero divisor.
                out_quot  <= w_dbz ? DBZ_QUOT : div_quot;
                out_rem   <= w_dbz ? w_head_a : div_rem;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : div_req_ctrl
`default_nettype wire

// File: tb/tb_div_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_req_ctrl
//  Description : Self-checking bench for div_req_ctrl. A behavioural model
//                (request queue + output holding register, arithmetic
//                division) predicts every output after each clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_req_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  b;
        logic [3:0]  tag;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_tag;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic [15:0] div_quot;
    logic [15:0] div_rem;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_quot;
    logic [15:0] out_rem;
    logic [3:0]  out_tag;
    logic        out_dbz;
    logic [2:0]  count;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    // Model state
    req_t        m_fifo[$];
    logic        m_ov;
    logic [15:0] m_quot;
    logic [15:0] m_rem;
    logic [3:0]  m_tag;
    logic        m_dbz;

    always #5 clk = ~clk;

    // Combinational core; garbage on divide-by-zero so ignoring it is visible.
    assign div_quot = (div_b != 8'd0) ? div_a / {8'd0, div_b} : 16'hDEAD;
    assign div_rem  = (div_b != 8'd0) ? div_a % {8'd0, div_b} : 16'hBEEF;

    div_req_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_tag   (out_tag),
        .out_dbz   (out_dbz),
        .count     (count),
        .busy      (busy)
    );

    function automatic void model_reset();
        m_fifo.delete();
        m_ov = 1'b0; m_quot = '0; m_rem = '0; m_tag = '0; m_dbz = 1'b0;
    endfunction

    // Advance the model across one rising edge using the inputs currently
    // applied, then wait for that edge and step 1 time unit past it.
    task automatic tick();
        bit   push;
        bit   cap;
        req_t h;
        push = in_valid && (m_fifo.size() < DEPTH);
        cap  = (m_fifo.size() != 0) && (!m_ov || out_ready);
        if (cap) begin
            h = m_fifo.pop_front();
            m_ov  = 1'b1;
            m_tag = h.tag;
            if (h.b == 8'd0) begin
                m_quot = 16'hFFFF; m_rem = h.a; m_dbz = 1'b1;
            end else begin
                m_quot = h.a / {8'd0, h.b}; m_rem = h.a % {8'd0, h.b}; m_dbz = 1'b0;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (push) m_fifo.push_back('{a: in_a, b: in_b, tag: in_tag});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [66:0] model_vec();
        logic [36:0] f;
        logic [15:0] ha;
        logic [7:0]  hb;
        f  = m_ov ? {m_quot, m_rem, m_tag, m_dbz} : 37'd0;
        ha = (m_fifo.size() != 0) ? m_fifo[0].a : 16'd0;
        hb = (m_fifo.size() != 0) ? m_fifo[0].b : 8'd0;
        return {m_ov, f, 3'(m_fifo.size()), (m_fifo.size() < DEPTH),
                ((m_fifo.size() != 0) || m_ov), ha, hb};
    endfunction

    function automatic logic [66:0] dut_vec();
        logic [36:0] f;
        f = out_valid ? {out_quot, out_rem, out_tag, out_dbz} : 37'd0;
        return {out_valid, f, count, in_ready, busy, div_a, div_b};
    endfunction

    task automatic set_req(input logic v, input logic [15:0] a, input logic [7:0] b,
                           input logic [3:0] t);
        in_valid = v; in_a = a; in_b = b; in_tag = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, out_quot, out_rem, out_tag, out_dbz, count, in_ready, busy, div_a, div_b}
            !== {1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b q=%h r=%h t=%h dbz=%b cnt=%0d rdy=%b busy=%b a=%h b=%h, want all zero with rdy=1",
                     out_valid, out_quot, out_rem, out_tag, out_dbz, count, in_ready, busy, div_a, div_b);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_req(1'b1, 16'd100, 8'd7, 4'd3);
        tick();
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        vectors++;
        if (out_valid !== 1'b0 || div_a !== 16'd100 || div_b !== 8'd7) begin
            errors++;
            $display("FAIL single_accept: got v=%b a=%0d b=%0d, want v=0 a=100 b=7", out_valid, div_a, div_b);
        end
        tick();
        vectors++;
        if ({out_valid, out_quot, out_rem, out_tag, out_dbz} !== {1'b1, 16'd14, 16'd2, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL single_result: got v=%b q=%0d r=%0d t=%0d dbz=%b, want 1 14 2 3 0",
                     out_valid, out_quot, out_rem, out_tag, out_dbz);
        end
        tick();
        vectors++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL single_drain: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_dbz();
        out_ready = 1'b1;
        set_req(1'b1, 16'h1234, 8'd0, 4'd5);
        tick();
        set_req(1'b1, 16'd9, 8'd3, 4'd6);
        tick();
        vectors++;
        if ({out_valid, out_quot, out_rem, out_dbz} !== {1'b1, 16'hFFFF, 16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result: got v=%b q=%h r=%h dbz=%b, want 1 ffff 1234 1",
                     out_valid, out_quot, out_rem, out_dbz);
        end
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        tick();
        vectors++;
        if ({out_valid, out_quot, out_rem, out_tag, out_dbz} !== {1'b1, 16'd3, 16'd0, 4'd6, 1'b0}) begin
            errors++;
            $display("FAIL dbz_next: got v=%b q=%0d r=%0d t=%0d dbz=%b, want 1 3 0 6 0",
                     out_valid, out_quot, out_rem, out_tag, out_dbz);
        end
        tick();
    endtask

    task automatic test_fill();
        int accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready === 1'b1) accepted++;
            set_req(1'b1, 16'($urandom), 8'($urandom_range(1, 255)), 4'(i));
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL fill_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (accepted != 5 || count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got accepted=%0d count=%0d rdy=%b, want 5 4 0", accepted, count, in_ready);
        end
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec() || out_valid !== (i < 4)) begin
                errors++;
                $display("FAIL fill_drain%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ca [3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        logic [7:0]  cb [3] = '{8'h01, 8'hFF, 8'h05};
        int run = 0;
        int best = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 3)       set_req(1'b1, ca[i], cb[i], 4'(i));
            else if (i < 16) set_req(1'b1, 16'($urandom), 8'($urandom), 4'(i));
            else             set_req(1'b0, 16'd0, 8'd0, 4'd0);
            tick();
            vectors++;
            if (dut_vec() !== model_vec() || (i < 16 && in_ready !== 1'b1)) begin
                errors++;
                $display("FAIL stream%0d: got %h want %h", i, dut_vec(), model_vec());
            end
            run  = out_valid ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        vectors++;
        if (best != 16) begin
            errors++;
            $display("FAIL stream_run: got %0d consecutive results, want 16", best);
        end
        tick();
    endtask

    task automatic test_random_stall();
        logic [36:0] held;
        logic        was_stalled;
        was_stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 300; i++) begin
            if (i < 260)
                set_req(1'($urandom_range(0, 1)), 16'($urandom),
                        ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom), 4'($urandom));
            else
                set_req(1'b0, 16'd0, 8'd0, 4'd0);
            out_ready = (i < 260) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            was_stalled = out_valid && !out_ready;
            held = {out_quot, out_rem, out_tag, out_dbz};
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random%0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (was_stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || {out_quot, out_rem, out_tag, out_dbz} !== held) begin
                    errors++;
                    $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", i, out_valid,
                             {out_quot, out_rem, out_tag, out_dbz}, held);
                end
            end
        end
        vectors++;
        if (busy !== 1'b0 || m_fifo.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 16'(100 + i), 8'd3, 4'(i));
            tick();
        end
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        vectors++;
        if (out_valid !== 1'b1 || count !== 3'd3) begin
            errors++;
            $display("FAIL midop_setup: got v=%b count=%0d, want 1 3", out_valid, count);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({out_valid, count, in_ready, busy, div_a, out_quot, out_rem, out_tag, out_dbz}
            !== {1'b0, 3'd0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: got v=%b count=%0d rdy=%b busy=%b a=%h q=%h r=%h, want 0 0 1 0 0 0 0",
                     out_valid, count, in_ready, busy, div_a, out_quot, out_rem);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        set_req(1'b1, 16'd50, 8'd8, 4'd9);
        tick();
        set_req(1'b0, 16'd0, 8'd0, 4'd0);
        tick();
        vectors++;
        if ({out_valid, out_quot, out_rem, out_tag, out_dbz} !== {1'b1, 16'd6, 16'd2, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: got v=%b q=%0d r=%0d t=%0d, want 1 6 2 9",
                     out_valid, out_quot, out_rem, out_tag);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbz();
        test_fill();
        test_back_to_back();
        test_random_stall();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_div_req_ctrl
`default_nettype wire
